// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl
// Description : Operand store and skewed-feed sequencer for a 4x4 systolic
//               multiply array (clear, feed, drain, done).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  load_we_i,
  input  logic                  load_sel_i,
  input  logic [3:0]            load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_1,
  output logic [DATA_WIDTH-1:0] left_o_2,
  output logic [DATA_WIDTH-1:0] left_o_3,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3,
  output logic                  array_clr_no,
  output logic                  feed_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // The step counter is shared by FEED (7 steps) and DRAIN (DRAIN_CYCLES steps).
  localparam int STEP_MAX   = (DRAIN_CYCLES > 7) ? DRAIN_CYCLES - 1 : 6;
  localparam int STEP_W     = $clog2(STEP_MAX + 1);
  localparam int FEED_STEPS = 7;
  localparam int DRAIN_END  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(FEED_STEPS - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_END);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam bit                SKIP_DRAIN = (DRAIN_CYCLES == 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DATA_WIDTH-1:0] a_q [16];
  logic [DATA_WIDTH-1:0] b_q [16];
  logic [DATA_WIDTH-1:0] left_w [4];
  logic [DATA_WIDTH-1:0] up_w [4];
  logic                  wr_en;

  assign wr_en = load_we_i && (state_q == S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 16; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (wr_en) begin
      if (load_sel_i) begin
        b_q[load_addr_i] <= load_data_i;
      end else begin
        a_q[load_addr_i] <= load_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          step_d  = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        step_d  = '0;
      end
      S_FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = SKIP_DRAIN ? S_DONE : S_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_ONE;
        end
      end
      S_DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    array_clr_no = (state_q != S_CLEAR);
    feed_valid_o = (state_q == S_FEED);
    done_o       = (state_q == S_DONE);
  end

  // Lane g sees element k = t-g of its row/column while 0 <= k <= 3.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [1:0] lane_k;
    logic       lane_on;

    always_comb begin
      lane_on  = (state_q == S_FEED) &&
                 (step_q >= STEP_W'(g)) && (step_q <= STEP_W'(g + 3));
      lane_k   = 2'(step_q - STEP_W'(g));
      left_w[g] = '0;
      up_w[g]   = '0;
      if (lane_on) begin
        left_w[g] = a_q[{2'(g), lane_k}];
        up_w[g]   = b_q[{lane_k, 2'(g)}];
      end
    end
  end

  assign left_o_0 = left_w[0];
  assign left_o_1 = left_w[1];
  assign left_o_2 = left_w[2];
  assign left_o_3 = left_w[3];
  assign up_o_0   = up_w[0];
  assign up_o_1   = up_w[1];
  assign up_o_2   = up_w[2];
  assign up_o_3   = up_w[3];

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_seq_ctrl
// Description : Scoreboard bench for systolic_seq_ctrl with a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk;
  logic          rst_ni, start_i, load_we_i, load_sel_i;
  logic [3:0]    load_addr_i;
  logic [DW-1:0] load_data_i;
  logic [DW-1:0] l0, l1, l2, l3, u0, u1, u2, u3;
  logic          clr_n, fv, busy, done;

  logic          start_z;
  logic [DW-1:0] zl0, zl1, zl2, zl3, zu0, zu1, zu2, zu3;
  logic          zclr_n, zfv, zbusy, zdone;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(D)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .load_we_i(load_we_i),
    .load_sel_i(load_sel_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .left_o_0(l0), .left_o_1(l1), .left_o_2(l2), .left_o_3(l3),
    .up_o_0(u0), .up_o_1(u1), .up_o_2(u2), .up_o_3(u3),
    .array_clr_no(clr_n), .feed_valid_o(fv), .busy_o(busy), .done_o(done)
  );

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(0)) u_dut_nd (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_z), .load_we_i(1'b0),
    .load_sel_i(load_sel_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .left_o_0(zl0), .left_o_1(zl1), .left_o_2(zl2), .left_o_3(zl3),
    .up_o_0(zu0), .up_o_1(zu1), .up_o_2(zu2), .up_o_3(zu3),
    .array_clr_no(zclr_n), .feed_valid_o(zfv), .busy_o(zbusy), .done_o(zdone)
  );

  typedef struct packed {
    logic [3:0][DW-1:0] l;
    logic [3:0][DW-1:0] u;
  } beat_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];
  int            free_edge = 0;
  int            cur_accept = -1;
  beat_t         feed_q[$];
  int            done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  // A job accepted at edge n: CLEAR after n, FEED after n+1..n+7,
  // DONE after n+8+D, idle again for an accept at n+10+D.
  task automatic model_accept(input int n);
    beat_t b;
    cur_accept = n;
    free_edge  = n + 10 + D;
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++) begin
        b.l[i] = (t - i >= 0 && t - i <= 3) ? ma[i*4 + t - i] : '0;
        b.u[i] = (t - i >= 0 && t - i <= 3) ? mb[(t - i)*4 + i] : '0;
      end
      feed_q.push_back(b);
    end
    done_q.push_back(n + 8 + D);
  endtask

  task automatic drive(input bit st, input bit we, input bit sel,
                       input logic [3:0] addr, input logic [DW-1:0] data);
    @(posedge clk);
    #1;
    start_i = st; load_we_i = we; load_sel_i = sel;
    load_addr_i = addr; load_data_i = data;
    if (cyc + 1 >= free_edge) begin
      if (we) begin
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
      end
      if (st) model_accept(cyc + 1);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, '0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (cyc + 1 >= free_edge) break;
      idle();
    end
    chk(cyc + 1 >= free_edge, "wait_idle budget expired");
    idle();
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    feed_q.delete();
    done_q.delete();
    cur_accept = -1;
    free_edge  = 0;
  endtask

  task automatic reset_now();
    rst_ni = 1'b0; start_i = 1'b0; load_we_i = 1'b0;
    #1;
    chk({l0, l1, l2, l3, u0, u1, u2, u3} == '0 && !fv && !busy && !done && clr_n,
        $sformatf("async_reset got fv=%0b busy=%0b done=%0b clr_n=%0b l0=%h u0=%h exp 0/0/0/1 zeros",
                  fv, busy, done, clr_n, l0, u0));
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
  endtask

  task automatic nd_test();
    int s, fv_last;
    bit got;
    @(posedge clk); #1;
    start_z = 1'b1;
    s = cyc + 1;
    @(posedge clk); #1;
    start_z = 1'b0;
    got = 1'b0;
    fv_last = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (zdone) begin
        got = 1'b1;
        chk(cyc == s + 8 && fv_last == cyc - 1,
            $sformatf("nodrain_done got edge=%0d last_feed=%0d exp edge=%0d last_feed=%0d",
                      cyc - s, fv_last - s, 8, 7));
      end
      if (zfv) fv_last = cyc;
    end
    if (!got) chk(1'b0, "nodrain_done timeout waiting for done_o");
    repeat (2) @(posedge clk);
  endtask

  int    m_off;
  bit    e_busy, e_clr, e_fv;
  beat_t act, expb;
  int    exp_edge;

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk({l0, l1, l2, l3, u0, u1, u2, u3} == '0 && !fv && !busy && !done && clr_n,
          $sformatf("reset_hold got fv=%0b busy=%0b done=%0b clr_n=%0b exp 0/0/0/1",
                    fv, busy, done, clr_n));
    end else begin
      m_off  = (cur_accept >= 0) ? cyc - cur_accept : -1;
      e_busy = (m_off >= 0) && (m_off <= 8 + D);
      e_clr  = (m_off != 0);
      e_fv   = (m_off >= 1) && (m_off <= 7);
      chk({busy, clr_n, fv} == {e_busy, e_clr, e_fv},
          $sformatf("status cyc=%0d got busy/clr_n/fv=%b exp %b",
                    cyc, {busy, clr_n, fv}, {e_busy, e_clr, e_fv}));
      act.l = {l3, l2, l1, l0};
      act.u = {u3, u2, u1, u0};
      if (fv) begin
        if (feed_q.size() == 0) begin
          chk(1'b0, $sformatf("feed_beat cyc=%0d got unexpected beat exp none", cyc));
        end else begin
          expb = feed_q.pop_front();
          chk(act == expb, $sformatf("feed_beat cyc=%0d got l=%h u=%h exp l=%h u=%h",
                                     cyc, act.l, act.u, expb.l, expb.u));
        end
      end else begin
        chk(act == '0, $sformatf("idle_feeds cyc=%0d got l=%h u=%h exp 0", cyc, act.l, act.u));
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk(1'b0, $sformatf("done_pulse cyc=%0d got unexpected done exp none", cyc));
        end else begin
          exp_edge = done_q.pop_front();
          chk(cyc == exp_edge, $sformatf("done_pulse got edge=%0d exp edge=%0d", cyc, exp_edge));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; load_we_i = 1'b0; load_sel_i = 1'b0;
    load_addr_i = '0; load_data_i = '0; start_z = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;

    nd_test();

    // Identity A, B[r][c] = 4r+c+1.
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b0, 4'(k), (k / 4 == k % 4) ? 1 : 0);
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 1'b1, 4'(k), DW'(k + 1));
    drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    wait_idle();

    // Write plus start while busy are both dropped.
    drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    repeat (4) idle();
    drive(1'b1, 1'b1, 1'b1, 4'd0, 32'hFF);
    wait_idle();
    drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    wait_idle();

    // Same-cycle write and start in IDLE.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd7);
    wait_idle();

    // Start held high back to back.
    repeat (45) drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    wait_idle();

    repeat (400) drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                       1'($urandom), 4'($urandom), DW'($urandom));
    wait_idle();

    // Reset mid-FEED (t=3), then a readback job over cleared storage.
    drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    repeat (5) idle();
    reset_now();
    drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
    wait_idle();

    repeat (3) idle();
    chk(feed_q.size() == 0 && done_q.size() == 0,
        $sformatf("scoreboard_drain got feeds=%0d dones=%0d exp 0/0", feed_q.size(), done_q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width of each A/B element.
REQ-002 Parameter DRAIN_CYCLES, default 4, zero-feed cycles after the last operand before done.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  request one 4x4 multiply job; sampled only in IDLE.
REQ-006 load_we_i  input  1  operand write strobe; honoured only in IDLE.
REQ-007 load_sel_i  input  1  write target: 0 selects matrix A, 1 selects matrix B.
REQ-008 load_addr_i  input  4  element index, row*4+col.
REQ-009 load_data_i  input  DATA_WIDTH  element value.
REQ-010 left_o_0..left_o_3  output  DATA_WIDTH each  skewed A-row feeds to array rows 0..3.
REQ-011 up_o_0..up_o_3  output  DATA_WIDTH each  skewed B-column feeds to array columns 0..3.
REQ-012 array_clr_no  output  1  active-low accumulator clear for the PE array.
REQ-013 feed_valid_o  output  1  high in every FEED cycle.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle completion pulse.

Function
REQ-016 Storage SHALL be two 16-entry DATA_WIDTH register arrays, A and B, written in IDLE when load_we_i=1.
REQ-017 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, DONE, with one step counter (0..max(6, DRAIN_CYCLES-1)).
REQ-018 IDLE -> CLEAR when start_i=1; otherwise it SHALL stay in IDLE.
REQ-019 CLEAR SHALL last exactly 1 cycle with array_clr_no=0, then go to FEED with step=0.
REQ-020 FEED SHALL last 7 cycles, step t=0..6, then go to DRAIN with step=0.
REQ-021 In FEED step t: left_o_i = A[i][t-i] if 0<=t-i<=3, else 0.
REQ-022 In FEED step t: up_o_j = B[t-j][j] if 0<=t-j<=3, else 0.
REQ-023 DRAIN SHALL last DRAIN_CYCLES cycles with all feed outputs 0, then go to DONE.
REQ-024 DRAIN_CYCLES=0 SHALL skip DRAIN, going FEED -> DONE.
REQ-025 DONE SHALL last 1 cycle with done_o=1, then return unconditionally to IDLE.
REQ-026 Outside FEED, all left_o_*/up_o_* SHALL be 0 and feed_valid_o SHALL be 0.
REQ-027 array_clr_no SHALL be 1 in every state except CLEAR.
REQ-028 A start_i or load_we_i while busy_o=1 SHALL be ignored, with no queuing and storage unchanged.
REQ-029 start_i and load_we_i together in IDLE: the write SHALL commit and the start SHALL be accepted; the job SHALL use the written value.
REQ-030 Start-to-done latency SHALL be exactly 1+7+DRAIN_CYCLES+1 clock edges (13 at default).
REQ-031 Feed values SHALL be passed through unmodified; no arithmetic is performed on the data.

Reset
REQ-032 rst_ni=0 SHALL immediately force state IDLE, step=0, and A and B storage to 0.
REQ-033 During rst_ni=0, outputs SHALL be: all feeds=0, feed_valid_o=0, busy_o=0, done_o=0, array_clr_no=1.
REQ-034 Reset asserted mid-job SHALL abort the job with no done_o pulse.
REQ-035 After rst_ni deasserts, the next job SHALL require a fresh start_i.

Verification
REQ-036 Load A=identity and B[r][c]=4r+c+1, pulse start_i: array_clr_no=0 for 1 cycle; FEED t=0 gives left_o_0=1, up_o_0=1; t=3 gives up_o_3=4 and up_o_0=13; t=6 gives left_o_3=1, up_o_3=16; done_o is high on the 13th edge after start.
REQ-037 Assert reset during FEED t=3: all outputs 0 at once, busy_o=0, array_clr_no=1; a later readback run shows A and B all zero.
REQ-038 During FEED, write B[0]=0xFF and pulse start_i: no restart, and the next job feeds the original B[0][0].
REQ-039 In IDLE, assert start_i and load_we_i (A[0]=7) in the same cycle: the job starts, and left_o_0=7 at FEED t=0.
REQ-040 Hold start_i high continuously: done_o pulses every 14 cycles, and busy_o is low exactly 1 cycle between jobs.
REQ-041 With DRAIN_CYCLES=0: done_o asserts in the cycle immediately after FEED t=6.
